branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side counterpart to the execute-stage branch condition evaluator.
- Predicts conditional-branch outcome and target at fetch. Each resolved result (taken/not-taken from the branch condition logic) is written back to train the predictor.
- Direct-mapped BTB with a 2-bit saturating counter per entry.
- Keeps running branch and mispredict counts for performance measurement.

Parameters:
- ENTRIES, 64, number of BTB entries; power of 2, minimum 4. IDX = log2(ENTRIES).
- TAG_BITS, 10, tag width; tag = pc[IDX+2+TAG_BITS-1 : IDX+2]. Requires IDX+2+TAG_BITS <= 32.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- lookup_pc  in  32  fetch PC, word aligned
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  pred_hit and counter[1]
- pred_target  out  32  stored target if pred_taken, else lookup_pc+4
- upd_valid  in  1  one resolved conditional branch this cycle
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  resolved outcome from the condition evaluator
- upd_target  in  32  resolved taken target
- upd_pred_taken  in  1  prediction carried down the pipe for this branch
- upd_pred_target  in  32  predicted next PC carried down the pipe
- flush_all  in  1  synchronous invalidate of all entries (fence.i)
- mispredict  out  1  combinational; upd_valid and prediction wrong
- branch_count  out  32  resolved branches since reset
- mispredict_count  out  32  mispredicts since reset

Behaviour:
- Reset (rst_n low, asynchronous):
  - All valid bits = 0; all counters = WNT (2'b01).
  - Tag and target arrays are not reset.
  - branch_count = 0, mispredict_count = 0.
  - Lookup outputs then read pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4.
  - Reset asserted mid-update drops that update.
- Lookup:
  - Purely combinational, zero latency.
  - idx = lookup_pc[IDX+1:2]; hit = valid[idx] and tag[idx] == lookup tag.
  - pred_target = lookup_pc + 4 (mod 2^32) when not pred_taken.
- mispredict = upd_valid and ((upd_pred_taken != upd_taken) or (upd_taken and upd_pred_target != upd_target)).
- Update, at posedge when upd_valid = 1; index/tag taken from upd_pc:
  - Hit: counter saturating +1 if taken, -1 if not taken; ST stays ST, SNT stays SNT. If taken, target = upd_target.
  - Miss and taken: allocate, overwriting any occupant. Set valid = 1, tag, target = upd_target, counter = WT (2'b10).
  - Miss and not taken: no table change.
  - branch_count += 1. mispredict_count += 1 if mispredict.
  - Both counters wrap modulo 2^32 with no saturation.
- Same-cycle lookup and update to the same index: lookup sees pre-update state; no bypass.
- flush_all at posedge:
  - All valid = 0 and counters = WNT.
  - Takes priority over a simultaneous update's table write, but statistics from that update still increment.
  - Does not clear statistics.
- upd_valid = 0: no state change besides flush_all.
- Lookup PC bits [1:0] are ignored.

Decomposition:
- Package bp_pkg:
  - Localparams SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11.
  - XLEN = 32.
  - Typedef bp_ctr_t (2-bit).
  - Typedef bp_entry_t (valid, tag, target, ctr).
- Sub-module bp_sat_ctr: combinational next-counter from (ctr, taken). Instantiated once on the update path.
- Arrays live in branch_predictor. Index/tag slicing is done by functions in the package.

Test Plan:
- Reset, then lookup_pc = 0x100 → pred_hit = 0, pred_taken = 0, pred_target = 0x104; both stat counters = 0.
- Update pc = 0x100, taken, target 0x80, pred_taken = 0 → mispredict = 1. Next cycle lookup 0x100 → hit, pred_taken = 1, pred_target = 0x80; counts = 1/1.
- Three more taken updates on 0x100 (ST saturation), then one not-taken → still pred_taken = 1. A second not-taken → pred_taken = 0, pred_target = 0x104.
- Alias: allocate 0x100, then taken update at 0x100 + 4·ENTRIES (same index, different tag) → lookup 0x100 misses; the new PC hits with the new target.
- Same-cycle lookup and update on 0x200 (first allocate) → lookup shows miss that cycle, hit the next. Also: flush_all concurrent with an update → table empty afterwards, branch_count still increments.
- Drive rst_n low asynchronously between edges during an update → outputs clear immediately. With 2^32−1 preloaded by force, one update makes branch_count wrap to 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types, counter encodings and PC slicing helpers for the branch predictor.
package bp_pkg;

    localparam int unsigned XLEN    = 32;
    // Widest tag any legal configuration can use (index is at least 2 bits).
    localparam int unsigned TAG_MAX = XLEN - 4;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t SNT = 2'b00;
    localparam bp_ctr_t WNT = 2'b01;
    localparam bp_ctr_t WT  = 2'b10;
    localparam bp_ctr_t ST  = 2'b11;

    // One BTB entry as seen by the lookup path; tag is zero-extended to TAG_MAX.
    typedef struct packed {
        logic                valid;
        logic [TAG_MAX-1:0]  tag;
        logic [XLEN-1:0]     target;
        bp_ctr_t             ctr;
    } bp_entry_t;

    // Table index: pc[idx_bits+1:2], returned zero-extended.
    function automatic logic [XLEN-1:0] bp_index(input logic [XLEN-1:0] pc,
                                                 input int unsigned     idx_bits);
        logic [XLEN-1:0] mask;
        mask = (XLEN'(1) << idx_bits) - XLEN'(1);
        return (pc >> 2) & mask;
    endfunction

    // Tag: pc[idx_bits+2+tag_bits-1 : idx_bits+2], returned zero-extended.
    function automatic logic [TAG_MAX-1:0] bp_tag(input logic [XLEN-1:0] pc,
                                                  input int unsigned     idx_bits,
                                                  input int unsigned     tag_bits);
        logic [XLEN-1:0] mask;
        mask = (XLEN'(1) << tag_bits) - XLEN'(1);
        return TAG_MAX'((pc >> (idx_bits + 2)) & mask);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next value of a 2-bit saturating direction counter.
//   ctr       : current counter
//   taken     : resolved outcome
//   ctr_nxt_c : counter after training (combinational)
module bp_sat_ctr
    import bp_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_nxt_c
);

    always_comb begin
        ctr_nxt_c = ctr;
        if (taken) begin
            if (ctr != ST) ctr_nxt_c = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_nxt_c = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped BTB with 2-bit direction counters, trained by
// resolved conditional branches, plus branch/mispredict statistics.
//   clk, rst_n              : clock, async active-low reset
//   lookup_pc               : fetch PC (bits [1:0] ignored)
//   pred_hit/taken/target   : combinational prediction for lookup_pc
//   upd_*                   : one resolved branch per cycle for training
//   flush_all               : synchronous invalidate of the whole table
//   mispredict              : combinational, resolved branch was mispredicted
//   branch_count            : resolved branches since reset (wraps)
//   mispredict_count        : mispredicts since reset (wraps)
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned TAG_BITS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    input  logic            flush_all,
    output logic            mispredict,
    output logic [XLEN-1:0] branch_count,
    output logic [XLEN-1:0] mispredict_count
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    logic                valid_q  [ENTRIES];
    bp_ctr_t             ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];

    logic [XLEN-1:0]     branch_cnt_q;
    logic [XLEN-1:0]     mispred_cnt_q;

    logic [IDX-1:0]      lk_idx;
    logic [TAG_MAX-1:0]  lk_tag;
    bp_entry_t           lk_ent;

    logic [IDX-1:0]      up_idx;
    logic [TAG_MAX-1:0]  up_tag;
    logic                up_hit;
    bp_ctr_t             up_ctr_nxt_c;

    // Lookup: reads the pre-update table, so a same-cycle update is not visible.
    always_comb begin
        lk_idx = IDX'(bp_index(lookup_pc, IDX));
        lk_tag = bp_tag(lookup_pc, IDX, TAG_BITS);
        lk_ent = '{valid:  valid_q[lk_idx],
                   tag:    TAG_MAX'(tag_q[lk_idx]),
                   target: target_q[lk_idx],
                   ctr:    ctr_q[lk_idx]};
        pred_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
        pred_taken  = pred_hit && (lk_ent.ctr >= WT);
        pred_target = pred_taken ? lk_ent.target : lookup_pc + XLEN'(4);
    end

    // Update-side index/tag decode and hit detection.
    always_comb begin
        up_idx = IDX'(bp_index(upd_pc, IDX));
        up_tag = bp_tag(upd_pc, IDX, TAG_BITS);
        up_hit = valid_q[up_idx] && (TAG_MAX'(tag_q[up_idx]) == up_tag);
    end

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    bp_sat_ctr u_sat_ctr (
        .ctr       (ctr_q[up_idx]),
        .taken     (upd_taken),
        .ctr_nxt_c (up_ctr_nxt_c)
    );

    // Valid bits and counters: reset, flush wins over training.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_nxt_c;
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= WT;
            end
        end
    end

    // Tag/target storage is not reset; it is only meaningful under a valid bit.
    // Any taken update either refreshes a hit's target or allocates.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken && !flush_all) begin
            tag_q[up_idx]    <= TAG_BITS'(up_tag);
            target_q[up_idx] <= upd_target;
        end
    end

    // Statistics keep counting through flushes and wrap modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_valid) begin
            branch_cnt_q <= branch_cnt_q + XLEN'(1);
            if (mispredict) mispred_cnt_q <= mispred_cnt_q + XLEN'(1);
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed plan steps, then randomized traffic,
// checked against a per-index behavioural model of the BTB.
module tb_branch_predictor;

    localparam int ENTRIES  = 64;
    localparam int TAG_BITS = 10;

    logic        clk;
    logic        rst_n;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .flush_all        (flush_all),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: per-index occupant, confidence 0..3, statistics.
    bit          m_valid [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit [31:0]   m_tag   [ENTRIES];
    bit [31:0]   m_tgt   [ENTRIES];
    bit [31:0]   m_bc;
    bit [31:0]   m_mc;

    function automatic int midx(input bit [31:0] pc);
        return int'((pc / 32'd4) % 32'(ENTRIES));
    endfunction

    function automatic bit [31:0] mtag(input bit [31:0] pc);
        return (pc / 32'(4 * ENTRIES)) % (32'd1 << TAG_BITS);
    endfunction

    task automatic mdl_clear_table();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic mdl_reset();
        mdl_clear_table();
        m_bc = '0;
        m_mc = '0;
    endtask

    task automatic mdl_lookup(input bit [31:0] pc, output bit hit, output bit tk,
                              output bit [31:0] tg);
        int i;
        i   = midx(pc);
        hit = m_valid[i] && (m_tag[i] == mtag(pc));
        tk  = hit && (m_ctr[i] >= 2);
        tg  = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, clock, train model.
    task automatic cycle(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utg, input logic ptk,
                         input logic [31:0] ptg, input logic fl);
        bit        h, t, mp;
        bit [31:0] g;
        int        i;
        @(negedge clk);
        lookup_pc       = lk;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
        flush_all       = fl;
        #1;
        mdl_lookup(lk, h, t, g);
        mp = uv && ((ptk != ut) || (ut && (ptg != utg)));
        chk("pred_hit",         32'(pred_hit),   32'(h));
        chk("pred_taken",       32'(pred_taken), 32'(t));
        chk("pred_target",      pred_target,     g);
        chk("mispredict",       32'(mispredict), 32'(mp));
        chk("branch_count",     branch_count,     m_bc);
        chk("mispredict_count", mispredict_count, m_mc);
        @(posedge clk);
        if (uv) begin
            m_bc = m_bc + 32'd1;
            if (mp) m_mc = m_mc + 32'd1;
        end
        if (fl) begin
            mdl_clear_table();
        end else if (uv) begin
            i = midx(upc);
            if (m_valid[i] && (m_tag[i] == mtag(upc))) begin
                if (ut) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                if (ut) m_tgt[i] = utg;
            end else if (ut) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = mtag(upc);
                m_tgt[i]   = utg;
                m_ctr[i]   = 2;
            end
        end
    endtask

    task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                      input logic ptk, input logic [31:0] ptg);
        cycle(pc, 1'b1, pc, tk, tg, ptk, ptg, 1'b0);
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; flush_all = 1'b0;
        mdl_reset();
        #12 rst_n = 1'b1;

        // Reset state
        look(32'h100);
        #2;
        chk("rst_hit",    32'(pred_hit),   32'd0);
        chk("rst_target", pred_target,     32'h104);
        chk("rst_bcount", branch_count,    32'd0);

        // First taken branch allocates, mispredicted
        br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        look(32'h100);
        #2;
        chk("alloc_target", pred_target,      32'h80);
        chk("alloc_mcount", mispredict_count, 32'd1);

        // Saturate to ST, then two not-taken steps
        repeat (3) br(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        br(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        look(32'h100);
        #2;
        chk("st_minus1_taken", 32'(pred_taken), 32'd1);
        br(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        look(32'h100);
        #2;
        chk("st_minus2_taken",  32'(pred_taken), 32'd0);
        chk("st_minus2_target", pred_target,     32'h104);

        // Flush, then same-cycle lookup/allocate on 0x200
        cycle(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        br(32'h200, 1'b1, 32'h2000, 1'b0, 32'h204);
        look(32'h200);
        #2;
        chk("samecyc_next_hit", 32'(pred_hit), 32'd1);

        // Alias on index 0: 0x100 evicts 0x200, then 0x200 evicts 0x100
        br(32'h100, 1'b1, 32'h1111_0000, 1'b0, 32'h104);
        br(32'h100 + 32'(4 * ENTRIES), 1'b1, 32'h3000, 1'b0, 32'h204);
        look(32'h100);
        #2;
        chk("alias_old_miss", 32'(pred_hit), 32'd0);
        look(32'h100 + 32'(4 * ENTRIES));
        #2;
        chk("alias_new_target", pred_target, 32'h3000);

        // Flush concurrent with an update: table empty, stats still count
        br(32'h300, 1'b1, 32'h4000, 1'b0, 32'h304);
        cycle(32'h300, 1'b1, 32'h300, 1'b1, 32'h5000, 1'b1, 32'h4000, 1'b1);
        look(32'h300);
        #2;
        chk("flush_upd_miss", 32'(pred_hit), 32'd0);

        // Randomized traffic over a small aliased PC pool
        for (int n = 0; n < 400; n++) begin
            bit [31:0] pc, lk, tg, ptg, g;
            bit        uv, tk, ptk, fl, h, t;
            pc = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 3)) << 8);
            if ($urandom_range(0, 1) == 0)
                lk = pc | 32'($urandom_range(0, 3));
            else
                lk = 32'h1000 + (32'($urandom_range(0, 7)) << 2) +
                     (32'($urandom_range(0, 3)) << 8) + 32'($urandom_range(0, 3));
            uv = ($urandom_range(0, 3) != 0);
            tk = 1'($urandom_range(0, 1));
            tg = $urandom & 32'hFFFF_FFFC;
            mdl_lookup(pc, h, t, g);
            if ($urandom_range(0, 3) != 0) begin
                ptk = t;
                ptg = g;
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = $urandom & 32'hFFFF_FFFC;
            end
            fl = ($urandom_range(0, 39) == 0);
            cycle(lk, uv, pc, tk, tg, ptk, ptg, fl);
        end

        // Asynchronous reset between edges while an update is pending
        br(32'h400, 1'b1, 32'h4400, 1'b0, 32'h404);
        @(negedge clk);
        lookup_pc = 32'h400; upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1;
        upd_target = 32'h5500; upd_pred_taken = 1'b0; upd_pred_target = 32'h504;
        flush_all = 1'b0;
        #1;
        chk("prereset_hit", 32'(pred_hit), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_hit",    32'(pred_hit),    32'd0);
        chk("async_target", pred_target,      32'h404);
        chk("async_bcount", branch_count,     32'd0);
        chk("async_mcount", mispredict_count, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_bcount", branch_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        upd_valid = 1'b0;
        mdl_reset();
        look(32'h500);
        look(32'h400);

        // Statistics wrap
        @(negedge clk);
        force dut.branch_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.branch_cnt_q;
        m_bc = 32'hFFFF_FFFF;
        br(32'h600, 1'b0, 32'h0, 1'b0, 32'h0);
        look(32'h600);
        #2;
        chk("wrap_bcount", branch_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
